// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone burst initiator.
// FSM state encoding plus fixed bus select and address stride.
package wb_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BUS,
    RDATA,
    ABORT,
    DRAIN,
    RESP
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
  localparam logic [31:0] WB_ADR_STEP = 32'd4;

endpackage

// File: rtl/wb_burst_initiator.sv
// Wishbone classic initiator: turns commands into single-word beats,
// streams write/read data and returns one status response per command.
module wb_burst_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_adr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [31:0]          wdata,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [31:0]          rdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_err,
  output logic [LEN_WIDTH-1:0] resp_count,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic [31:0]          wbm_dat_i
);

  localparam int unsigned TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t               state_q, state_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic [31:0]          rdat_q, rdat_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] drn_q, drn_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 wbwe_q, wbwe_d;
  logic                 crdy_q, crdy_d;
  logic                 wrdy_q, wrdy_d;
  logic                 rvld_q, rvld_d;
  logic                 resp_q, resp_d;
  logic                 tmo_hit;
  logic                 unused_adr;

  assign unused_adr = ^cmd_adr[1:0];

  assign tmo_hit = (TIMEOUT != 0) &&
                   ((tmo_q + TW'(1)) == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    we_d    = we_q;
    err_d   = err_q;
    tmo_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && crdy_q) begin
          adr_d = {cmd_adr[31:2], 2'b00};
          len_d = cmd_len;
          we_d  = cmd_we;
          cnt_d = '0;
          err_d = 1'b0;
          if (cmd_len == '0) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (cmd_we) begin
            state_d = WDATA;
          end else begin
            state_d = BUS;
          end
        end
      end
      WDATA: begin
        if (wdata_valid && wrdy_q) begin
          dat_d   = wdata;
          state_d = BUS;
        end
      end
      BUS: begin
        tmo_d = tmo_q + TW'(1);
        // err beats ack when both arrive together
        if (wbm_err_i) begin
          state_d = ABORT;
        end else if (wbm_ack_i) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          adr_d = adr_q + WB_ADR_STEP;
          if (!we_q) begin
            rdat_d  = wbm_dat_i;
            state_d = RDATA;
          end else if (cnt_d == len_q) begin
            state_d = RESP;
          end else begin
            state_d = WDATA;
          end
        end else if (tmo_hit) begin
          state_d = ABORT;
        end
      end
      RDATA: begin
        if (rdata_ready && rvld_q) begin
          state_d = (cnt_q == len_q) ? RESP : BUS;
        end
      end
      ABORT: begin
        err_d = 1'b1;
        // the failed write beat already consumed its data word
        if (we_q && ((cnt_q + LEN_WIDTH'(1)) < len_q)) begin
          drn_d   = len_q - cnt_q - LEN_WIDTH'(1);
          state_d = DRAIN;
        end else begin
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (wdata_valid && wrdy_q) begin
          drn_d = drn_q - LEN_WIDTH'(1);
          if (drn_q == LEN_WIDTH'(1)) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (resp_ready && resp_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cyc_d  = (state_d == WDATA) || (state_d == BUS) ||
             (state_d == RDATA);
    stb_d  = (state_d == BUS);
    wbwe_d = cyc_d && we_d;
    crdy_d = (state_d == IDLE);
    wrdy_d = (state_d == WDATA) || (state_d == DRAIN);
    rvld_d = (state_d == RDATA);
    resp_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      wbwe_q  <= 1'b0;
      crdy_q  <= 1'b0;
      wrdy_q  <= 1'b0;
      rvld_q  <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      wbwe_q  <= wbwe_d;
      crdy_q  <= crdy_d;
      wrdy_q  <= wrdy_d;
      rvld_q  <= rvld_d;
      resp_q  <= resp_d;
    end
  end

  assign cmd_ready   = crdy_q;
  assign wdata_ready = wrdy_q;
  assign rdata_valid = rvld_q;
  assign rdata       = rdat_q;
  assign resp_valid  = resp_q;
  assign resp_err    = err_q;
  assign resp_count  = cnt_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = cyc_q ? WB_SEL_ALL : 4'h0;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = wbwe_q;

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Directed bench for wb_burst_initiator with a small Wishbone slave
// whose wait states, error beat and read data are set per step.
module tb_wb_burst_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready = 1'b1;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_err;
  logic [7:0]  resp_count;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  always #5 clk = ~clk;

  wb_burst_initiator #(
    .TIMEOUT  (8),
    .LEN_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_err   (resp_err),
    .resp_count (resp_count),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i),
    .wbm_dat_i  (wbm_dat_i)
  );

  // slave: ack after slv_wait stb cycles, read data from address
  logic [31:0] rd_org = '0;
  logic [31:0] err_adr = '0;
  logic        err_en = 1'b0;
  logic        never_ack = 1'b0;
  int          slv_wait = 0;
  int          slv_cnt = 0;
  logic        hit;

  assign hit = wbm_stb_o && !never_ack && (slv_cnt == slv_wait);
  assign wbm_err_i = hit && err_en && (wbm_adr_o == err_adr);
  assign wbm_ack_i = hit && !wbm_err_i;
  assign wbm_dat_i = 32'hA0 + ((wbm_adr_o - rd_org) >> 2);

  always @(posedge clk) begin
    if (wbm_stb_o && !wbm_ack_i && !wbm_err_i) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end

  logic [31:0] wtbl [16];
  int          widx = 0;
  assign wdata = wtbl[widx[3:0]];

  logic [31:0] adr_log [$];
  logic [31:0] dat_log [$];
  logic [31:0] rd_log [$];
  logic        we_log [$];
  int cycle = 0, stb_cyc = 0, cyc_cyc = 0;
  int wd_hs = 0, drain_hs = 0, resp_hs = 0;
  int t_cmd = 0, t_resp = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (wbm_stb_o) stb_cyc <= stb_cyc + 1;
    if (wbm_cyc_o) cyc_cyc <= cyc_cyc + 1;
    if (wbm_stb_o && wbm_ack_i && !wbm_err_i) begin
      adr_log.push_back(wbm_adr_o);
      dat_log.push_back(wbm_dat_o);
      we_log.push_back(wbm_we_o);
    end
    if (wdata_valid && wdata_ready) begin
      widx  <= widx + 1;
      wd_hs <= wd_hs + 1;
      if (!wbm_cyc_o) drain_hs <= drain_hs + 1;
    end
    if (rdata_valid && rdata_ready) rd_log.push_back(rdata);
    if (cmd_valid && cmd_ready) t_cmd <= cycle;
    if (resp_valid && resp_ready) begin
      t_resp  <= cycle;
      resp_hs <= resp_hs + 1;
    end
  end

  int total = 0, passed = 0, failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr,
                          input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic e_err,
                           input logic [7:0] e_cnt);
    int n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    chk({tag, "_err"}, 32'(resp_err), 32'(e_err));
    chk({tag, "_count"}, 32'(resp_count), 32'(e_cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, r0, s0, w0, d0, c0, h0, n;
    logic [31:0] held;
    for (int i = 0; i < 16; i++) wtbl[i] = '0;

    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // read burst, zero-wait slave
    rd_org = 32'h100;
    a0 = adr_log.size(); r0 = rd_log.size(); s0 = stb_cyc;
    send_cmd(1'b0, 32'h100, 8'd3);
    wait_resp("rd3", 1'b0, 8'd3);
    chk("rd3_nrd", 32'(rd_log.size() - r0), 32'd3);
    chk("rd3_d0", rd_log[r0], 32'hA0);
    chk("rd3_d1", rd_log[r0 + 1], 32'hA1);
    chk("rd3_d2", rd_log[r0 + 2], 32'hA2);
    chk("rd3_a0", adr_log[a0], 32'h100);
    chk("rd3_a1", adr_log[a0 + 1], 32'h104);
    chk("rd3_a2", adr_log[a0 + 2], 32'h108);
    chk("rd3_we", 32'(we_log[a0]), 32'd0);
    chk("rd3_stb_cycles", 32'(stb_cyc - s0), 32'd3);
    chk("rd3_latency", 32'(t_resp - t_cmd), 32'd7);

    // write burst, two wait states
    slv_wait = 2;
    wtbl[widx[3:0]] = 32'h11;
    wtbl[4'(widx + 1)] = 32'h22;
    wdata_valid = 1'b1;
    a0 = adr_log.size(); s0 = stb_cyc; w0 = wd_hs;
    send_cmd(1'b1, 32'h200, 8'd2);
    wait_resp("wr2", 1'b0, 8'd2);
    chk("wr2_nack", 32'(adr_log.size() - a0), 32'd2);
    chk("wr2_a0", adr_log[a0], 32'h200);
    chk("wr2_a1", adr_log[a0 + 1], 32'h204);
    chk("wr2_d0", dat_log[a0], 32'h11);
    chk("wr2_d1", dat_log[a0 + 1], 32'h22);
    chk("wr2_we0", 32'(we_log[a0]), 32'd1);
    chk("wr2_we1", 32'(we_log[a0 + 1]), 32'd1);
    chk("wr2_stb_cycles", 32'(stb_cyc - s0), 32'd6);
    chk("wr2_wdata_hs", 32'(wd_hs - w0), 32'd2);
    chk("wr2_latency", 32'(t_resp - t_cmd), 32'd9);

    // write burst, error on second beat then drain
    slv_wait = 0;
    err_en = 1'b1;
    err_adr = 32'h304;
    for (int i = 0; i < 4; i++) wtbl[4'(widx + i)] = 32'h31 + 32'(i);
    a0 = adr_log.size(); w0 = wd_hs; d0 = drain_hs;
    send_cmd(1'b1, 32'h300, 8'd4);
    wait_resp("wrerr", 1'b1, 8'd1);
    err_en = 1'b0;
    chk("wrerr_nack", 32'(adr_log.size() - a0), 32'd1);
    chk("wrerr_a0", adr_log[a0], 32'h300);
    chk("wrerr_d0", dat_log[a0], 32'h31);
    chk("wrerr_wdata_hs", 32'(wd_hs - w0), 32'd4);
    chk("wrerr_drain_hs", 32'(drain_hs - d0), 32'd2);
    chk("wrerr_latency", 32'(t_resp - t_cmd), 32'd8);

    // ack timeout
    never_ack = 1'b1;
    s0 = stb_cyc; r0 = rd_log.size();
    send_cmd(1'b0, 32'h400, 8'd1);
    wait_resp("tmo", 1'b1, 8'd0);
    never_ack = 1'b0;
    chk("tmo_stb_cycles", 32'(stb_cyc - s0), 32'd8);
    chk("tmo_nrd", 32'(rd_log.size() - r0), 32'd0);
    chk("tmo_latency", 32'(t_resp - t_cmd), 32'd10);

    // zero length
    c0 = cyc_cyc;
    send_cmd(1'b0, 32'h500, 8'd0);
    wait_resp("len0", 1'b1, 8'd0);
    chk("len0_cyc_cycles", 32'(cyc_cyc - c0), 32'd0);
    chk("len0_latency", 32'(t_resp - t_cmd), 32'd1);

    // read data backpressure
    rdata_ready = 1'b0;
    rd_org = 32'h600;
    r0 = rd_log.size();
    send_cmd(1'b0, 32'h600, 8'd2);
    n = 0;
    while (!rdata_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(rdata_valid), 32'd1);
    held = rdata;
    chk("bp_first", held, 32'hA0);
    s0 = stb_cyc;
    repeat (5) @(negedge clk);
    chk("bp_hold_data", rdata, 32'hA0);
    chk("bp_hold_valid", 32'(rdata_valid), 32'd1);
    chk("bp_stb_low", 32'(wbm_stb_o), 32'd0);
    chk("bp_stb_cycles", 32'(stb_cyc - s0), 32'd0);
    rdata_ready = 1'b1;
    wait_resp("bp", 1'b0, 8'd2);
    chk("bp_nrd", 32'(rd_log.size() - r0), 32'd2);
    chk("bp_d1", rd_log[r0 + 1], 32'hA1);

    // address wrap, low address bits ignored
    rd_org = 32'hFFFF_FFFC;
    a0 = adr_log.size(); r0 = rd_log.size();
    send_cmd(1'b0, 32'hFFFF_FFFE, 8'd2);
    wait_resp("wrap", 1'b0, 8'd2);
    chk("wrap_a0", adr_log[a0], 32'hFFFF_FFFC);
    chk("wrap_a1", adr_log[a0 + 1], 32'h0);
    chk("wrap_d0", rd_log[r0], 32'hA0);
    chk("wrap_d1", rd_log[r0 + 1], 32'hA1);

    // reset in the middle of a write beat
    never_ack = 1'b1;
    wtbl[widx[3:0]] = 32'h77;
    h0 = resp_hs;
    send_cmd(1'b1, 32'h700, 8'd1);
    n = 0;
    while (!wbm_stb_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_stb", 32'(wbm_stb_o), 32'd1);
    chk("mid_we", 32'(wbm_we_o), 32'd1);
    chk("mid_sel", 32'(wbm_sel_o), 32'hF);
    chk("mid_dat", wbm_dat_o, 32'h77);
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("arst_stb", 32'(wbm_stb_o), 32'd0);
    chk("arst_we", 32'(wbm_we_o), 32'd0);
    repeat (2) @(negedge clk);
    never_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_no_resp", 32'(resp_valid), 32'd0);
    chk("arst_resp_hs", 32'(resp_hs - h0), 32'd0);

    // normal read after reset
    rd_org = 32'h800;
    r0 = rd_log.size();
    send_cmd(1'b0, 32'h800, 8'd1);
    wait_resp("after", 1'b0, 8'd1);
    chk("after_d0", rd_log[r0], 32'hA0);

    if (failed != 0) $display("%0d comparisons failed", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
